dff_link_rr_arbiter: RTL and testbench

Round-robin controller that shares one serial 4-stage DFF link between N_REQ requesters. It accepts a parallel word from the granted requester and serializes it LSB-first into the link. It then samples the link output after the link latency and reassembles the word, tagging it with the requester ID. It sits between the requester blocks and the DFF link, which is instantiated beside it and clocked by the same CLK.

---
 rtl/dff_link_pkg.sv | 20 ++
 rtl/rr_picker.sv | 32 +++
 rtl/dff_link_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_dff_link_rr_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dff_link_pkg.sv
// Shared types and constants for the round-robin DFF link arbiter.
// Holds the frame FSM encoding and the counter width helper.
package dff_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int WORD_W_DEF     = 4;
    localparam int LINK_DEPTH_DEF = 4;

    // cnt runs 0 .. w+d-1 within one frame
    function automatic int cnt_w(input int w, input int d);
        return (w + d > 1) ? $clog2(w + d) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active request after last_grant.
// Produces a one-hot grant and the matching encoded index.
module rr_picker #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int ID_W = $clog2(N_REQ);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(last_grant) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/dff_link_rr_arbiter.sv
// Shares one serial DFF link between N_REQ requesters, round-robin.
// Serializes the granted word LSB-first and reassembles it after the link.
module dff_link_rr_arbiter
    import dff_link_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int LINK_DEPTH = LINK_DEPTH_DEF,
    parameter int N_REQ      = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*WORD_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      link_data_out,
    input  logic                      link_data_in,
    output logic                      rx_valid,
    output logic [WORD_W-1:0]         rx_data,
    output logic [$clog2(N_REQ)-1:0]  rx_id,
    output logic                      busy
);

    localparam int CNT_W = cnt_w(WORD_W, LINK_DEPTH);
    localparam int ID_W  = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(WORD_W + LINK_DEPTH - 1);
    localparam logic [CNT_W-1:0] SAMPLE_FIRST = CNT_W'(LINK_DEPTH);
    localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(N_REQ - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
    logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              rx_valid_q, rx_valid_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic [ID_W-1:0]   rx_id_q, rx_id_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]   pick_idx;

    rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req       (req_valid),
        .last_grant(last_grant_q),
        .grant     (pick_grant),
        .idx       (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_reg_d   = shift_reg_q;
        rx_shift_d    = rx_shift_q;
        last_grant_d  = last_grant_q;
        cur_id_d      = cur_id_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_id_d       = rx_id_q;
        req_ready     = '0;
        link_data_out = 1'b0;

        // Window opens once the first driven bit has crossed the link
        if ((state_q == SHIFT || state_q == DRAIN) && cnt_q >= SAMPLE_FIRST)
            rx_shift_d = {link_data_in, rx_shift_q[WORD_W-1:1]};

        unique case (state_q)
            IDLE: begin
                if (!RST && |req_valid) begin
                    req_ready    = pick_grant;
                    shift_reg_d  = req_data[int'(pick_idx)*WORD_W +: WORD_W];
                    cur_id_d     = pick_idx;
                    last_grant_d = pick_idx;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                link_data_out = shift_reg_q[0];
                shift_reg_d   = shift_reg_q >> 1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == SHIFT_LAST)
                    state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DRAIN_LAST) begin
                    state_d    = DONE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_d;
                    rx_id_d    = cur_id_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_reg_q  <= '0;
            rx_shift_q   <= '0;
            last_grant_q <= LAST_ID;
            cur_id_q     <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_id_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_reg_q  <= shift_reg_d;
            rx_shift_q   <= rx_shift_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_id_q      <= rx_id_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_id    = rx_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dff_link_rr_arbiter.sv
// Directed bench: arbiter plus a 4-stage DFF link, hand-computed frames.
// Inputs change #1 after the rising edge; outputs are checked 1ns later.
module tb_dff_link_rr_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] req_valid = '0;
    logic [7:0] req_data = '0;
    logic [1:0] req_ready;
    logic       link_data_out;
    logic       link_data_in;
    logic       rx_valid;
    logic [3:0] rx_data;
    logic       rx_id;
    logic       busy;

    logic       fill_ones = 1'b0;
    logic [3:0] link_q = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK)
        link_q <= {link_q[2:0], fill_ones ? 1'b1 : link_data_out};

    assign link_data_in = link_q[3];

    dff_link_rr_arbiter dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .link_data_out(link_data_out),
        .link_data_in (link_data_in),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_id        (rx_id),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Called at the start of transfer cycle A; returns at start of A+10
    task automatic frame(input logic [1:0] v, input logic [7:0] d,
                         input int id, input logic [3:0] ed,
                         input bit keep, input string tag);
        logic [1:0] g;
        g = 2'b01 << id;
        req_valid = v;
        req_data  = d;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(g));
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                req_valid = keep ? v : (v & ~g);
                #1;
                chk({tag, ".busy"}, 32'(busy), 32'd1);
                chk({tag, ".noready"}, 32'(req_ready), 32'd0);
            end
            chk($sformatf("%s.bit%0d", tag, k), 32'(link_data_out), 32'(ed[k]));
        end
        repeat (4) tick();
        chk({tag, ".early"}, 32'(rx_valid), 32'd0);
        tick();
        chk({tag, ".rx_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(ed));
        chk({tag, ".rx_id"}, 32'(rx_id), 32'(id));
        tick();
        chk({tag, ".pulse"}, 32'(rx_valid), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".hold"}, 32'(rx_data), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1;
        chk("rst.rx_valid", 32'(rx_valid), 32'd0);
        chk("rst.rx_data", 32'(rx_data), 32'd0);
        chk("rst.rx_id", 32'(rx_id), 32'd0);
        chk("rst.link", 32'(link_data_out), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd0);
        tick();

        // Single request 4'b1011 from requester 0
        frame(2'b01, 8'h0B, 0, 4'hB, 1'b0, "single");

        // Both valid after reset: 0 first, then 1 at A+10
        req_valid = 2'b00;
        do_reset();
        frame(2'b11, 8'hA5, 0, 4'h5, 1'b0, "sim0");
        frame(2'b10, 8'hA5, 1, 4'hA, 1'b0, "sim1");

        // Both held continuously: 0, 1, 0 back to back
        req_valid = 2'b00;
        do_reset();
        frame(2'b11, 8'hA5, 0, 4'h5, 1'b1, "rr0");
        frame(2'b11, 8'hA5, 1, 4'hA, 1'b1, "rr1");
        frame(2'b11, 8'hA5, 0, 4'h5, 1'b1, "rr2");

        // Only req1, held through reset: no ready during RST
        req_valid = 2'b10;
        req_data  = 8'h60;
        RST = 1'b1;
        tick();
        tick();
        chk("only1.rst_ready", 32'(req_ready), 32'd0);
        RST = 1'b0;
        frame(2'b10, 8'h60, 1, 4'h6, 1'b0, "only1");

        // Stale ones in the link must not leak into a zero frame
        req_valid = 2'b00;
        do_reset();
        fill_ones = 1'b1;
        repeat (4) tick();
        fill_ones = 1'b0;
        chk("fill.link_in", 32'(link_data_in), 32'd1);
        frame(2'b01, 8'h00, 0, 4'h0, 1'b0, "stale");

        // Reset during DRAIN aborts; held req0 restarts right after
        req_valid = 2'b01;
        req_data  = 8'h09;
        #1;
        chk("abort.ready", 32'(req_ready), 32'd1);
        repeat (6) tick();
        chk("abort.busy_pre", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        chk("abort.rst_ready", 32'(req_ready), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.rx_valid", 32'(rx_valid), 32'd0);
        chk("abort.rx_data", 32'(rx_data), 32'd0);
        frame(2'b01, 8'h09, 0, 4'h9, 1'b0, "restart");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
